// File: rtl/read_arbiter_pkg.sv
// Shared definitions for the read-channel arbiter: bus width, FSM states
// and grant encodings used by the arbiter and its round-robin helper.
package read_arbiter_pkg;

    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        RD_ARB_IDLE = 2'd0,
        RD_ARB_ADDR = 2'd1,
        RD_ARB_DATA = 2'd2
    } rd_arb_state_t;

    typedef enum logic {
        RD_ARB_I = 1'b0,
        RD_ARB_D = 1'b1
    } rd_arb_grant_t;

    function automatic rd_arb_grant_t other_grant(input rd_arb_grant_t g);
        rd_arb_grant_t o;
        if (g == RD_ARB_I) o = RD_ARB_D;
        else               o = RD_ARB_I;
        return o;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-input round-robin winner: a lone requester wins,
// on a tie the requester that was not granted last wins.
module rr_arbiter2
    import read_arbiter_pkg::*;
(
    input  logic          req_i,
    input  logic          req_d,
    input  rd_arb_grant_t last_grant,
    output rd_arb_grant_t grant,
    output logic          any_req
);

    always_comb begin
        grant = RD_ARB_I;
        if (req_i && req_d) begin
            grant = other_grant(last_grant);
        end else if (req_d) begin
            grant = RD_ARB_D;
        end
    end

    assign any_req = req_i | req_d;

endmodule

// File: rtl/read_arbiter.sv
// Shares the single memory read channel between the instruction-read and
// data-read requesters, one transaction outstanding, responses routed back to the issuer.
module read_arbiter
    import read_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ir_addr_valid,
    output logic                 ir_addr_ready,
    input  logic [BUS_WIDTH-1:0] ir_addr,
    output logic                 ir_data_valid,
    input  logic                 ir_data_ready,
    output logic [BUS_WIDTH-1:0] ir_data,

    input  logic                 dr_addr_valid,
    output logic                 dr_addr_ready,
    input  logic [BUS_WIDTH-1:0] dr_addr,
    output logic                 dr_data_valid,
    input  logic                 dr_data_ready,
    output logic [BUS_WIDTH-1:0] dr_data,

    output logic                 r_addr_valid,
    input  logic                 r_addr_ready,
    output logic [BUS_WIDTH-1:0] r_addr,
    input  logic                 r_data_valid,
    output logic                 r_data_ready,
    input  logic [BUS_WIDTH-1:0] r_data,

    output logic                 protocol_error
);

    rd_arb_state_t        state, state_nxt;
    rd_arb_grant_t        owner, owner_nxt;
    rd_arb_grant_t        last_grant, last_grant_nxt;
    rd_arb_grant_t        win;
    logic                 win_any;

    rd_arb_grant_t        sel;
    logic                 sel_valid;
    logic [BUS_WIDTH-1:0] sel_addr;
    logic                 addr_rdy;
    logic                 data_rdy;

    rr_arbiter2 u_rr (
        .req_i      (ir_addr_valid),
        .req_d      (dr_addr_valid),
        .last_grant (last_grant),
        .grant      (win),
        .any_req    (win_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RD_ARB_IDLE;
            owner          <= RD_ARB_I;
            last_grant     <= RD_ARB_D;
            protocol_error <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            // Memory data is only legal while a transaction is in DATA.
            if (r_data_valid && (state != RD_ARB_DATA)) begin
                protocol_error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;

        r_addr_valid   = 1'b0;
        r_addr         = '0;
        r_data_ready   = 1'b0;
        ir_addr_ready  = 1'b0;
        dr_addr_ready  = 1'b0;
        ir_data_valid  = 1'b0;
        ir_data        = '0;
        dr_data_valid  = 1'b0;
        dr_data        = '0;
        addr_rdy       = 1'b0;
        data_rdy       = 1'b0;

        // The grant is free only in IDLE; afterwards it is locked to owner.
        sel = owner;
        if (state == RD_ARB_IDLE) begin
            sel = win;
        end
        sel_valid = (sel == RD_ARB_I) ? ir_addr_valid : dr_addr_valid;
        sel_addr  = (sel == RD_ARB_I) ? ir_addr : dr_addr;

        case (state)
            RD_ARB_IDLE: begin
                if (win_any) begin
                    r_addr_valid = 1'b1;
                    r_addr       = sel_addr;
                    addr_rdy     = r_addr_ready;
                    owner_nxt    = sel;
                    if (r_addr_ready) begin
                        state_nxt      = RD_ARB_DATA;
                        last_grant_nxt = sel;
                    end else begin
                        state_nxt = RD_ARB_ADDR;
                    end
                end
            end
            RD_ARB_ADDR: begin
                r_addr_valid = sel_valid;
                r_addr       = sel_addr;
                addr_rdy     = r_addr_ready;
                if (sel_valid && r_addr_ready) begin
                    state_nxt      = RD_ARB_DATA;
                    last_grant_nxt = owner;
                end
            end
            RD_ARB_DATA: begin
                data_rdy     = (owner == RD_ARB_I) ? ir_data_ready : dr_data_ready;
                r_data_ready = data_rdy;
                if (owner == RD_ARB_I) begin
                    ir_data_valid = r_data_valid;
                    ir_data       = r_data;
                end else begin
                    dr_data_valid = r_data_valid;
                    dr_data       = r_data;
                end
                if (r_data_valid && data_rdy) begin
                    state_nxt = RD_ARB_IDLE;
                end
            end
            default: begin
                state_nxt = RD_ARB_IDLE;
            end
        endcase

        ir_addr_ready = addr_rdy && (sel == RD_ARB_I);
        dr_addr_ready = addr_rdy && (sel == RD_ARB_D);

        // Outputs are quiet for as long as reset is held, whatever the inputs do.
        if (!rst) begin
            r_addr_valid  = 1'b0;
            r_addr        = '0;
            r_data_ready  = 1'b0;
            ir_addr_ready = 1'b0;
            dr_addr_ready = 1'b0;
            ir_data_valid = 1'b0;
            ir_data       = '0;
            dr_data_valid = 1'b0;
            dr_data       = '0;
        end
    end

endmodule

// File: tb/tb_read_arbiter.sv
// Scoreboard bench for read_arbiter: requester and memory models drive the
// DUT, a monitor checks every handshake against queued expectations.
module tb_read_arbiter;
    import read_arbiter_pkg::*;

    localparam logic [31:0] KEY = 32'hDEADBFEF; // memory returns addr ^ KEY

    logic        clk;
    logic        rst;
    logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
    logic [31:0] ir_addr, ir_data;
    logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
    logic [31:0] dr_addr, dr_data;
    logic        r_addr_valid, r_addr_ready, r_data_valid, r_data_ready;
    logic [31:0] r_addr, r_data;
    logic        protocol_error;

    read_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ir_addr_valid  (ir_addr_valid),
        .ir_addr_ready  (ir_addr_ready),
        .ir_addr        (ir_addr),
        .ir_data_valid  (ir_data_valid),
        .ir_data_ready  (ir_data_ready),
        .ir_data        (ir_data),
        .dr_addr_valid  (dr_addr_valid),
        .dr_addr_ready  (dr_addr_ready),
        .dr_addr        (dr_addr),
        .dr_data_valid  (dr_data_valid),
        .dr_data_ready  (dr_data_ready),
        .dr_data        (dr_data),
        .r_addr_valid   (r_addr_valid),
        .r_addr_ready   (r_addr_ready),
        .r_addr         (r_addr),
        .r_data_valid   (r_data_valid),
        .r_data_ready   (r_data_ready),
        .r_data         (r_data),
        .protocol_error (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_dhs_cyc = 0;
    int ir_dhs_cyc   = 0;
    int dr_ahs_cyc   = 0;
    int ir_dv_cycles = 0;
    int dr_dv_cycles = 0;

    logic [31:0] ir_q[$];
    logic [31:0] dr_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_ir[$];
    logic [31:0] exp_dr[$];

    int mem_lat    = 1;
    bit ir_dready  = 1'b1;
    bit dr_dready  = 1'b1;
    bit mem_aready = 1'b1;
    bit stray_req  = 1'b0;

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Requester and memory models
    bit          s_ir_ahs, s_dr_ahs, s_mem_ahs, s_mem_dhs;
    logic [31:0] s_mem_addr, paddr;
    bit          pend, stray_on;
    int          cnt;

    initial begin : bus_model
        ir_addr_valid = 1'b0; ir_addr = '0; dr_addr_valid = 1'b0; dr_addr = '0;
        ir_data_ready = 1'b0; dr_data_ready = 1'b0;
        r_addr_ready = 1'b0; r_data_valid = 1'b0; r_data = '0;
        pend = 1'b0; stray_on = 1'b0; cnt = 0; paddr = '0;
        forever begin
            @(negedge clk);
            s_ir_ahs   = ir_addr_valid && ir_addr_ready;
            s_dr_ahs   = dr_addr_valid && dr_addr_ready;
            s_mem_ahs  = r_addr_valid && r_addr_ready;
            s_mem_addr = r_addr;
            s_mem_dhs  = r_data_valid && r_data_ready;
            @(posedge clk);
            #1;
            if (!rst) begin
                ir_addr_valid = 1'b0; dr_addr_valid = 1'b0;
                ir_q.delete(); dr_q.delete();
                r_addr_ready = 1'b0; r_data_valid = 1'b0; r_data = '0;
                pend = 1'b0; stray_on = 1'b0;
            end else begin
                if (s_ir_ahs) ir_addr_valid = 1'b0;
                if (!ir_addr_valid && ir_q.size() > 0) begin
                    ir_addr = ir_q.pop_front(); ir_addr_valid = 1'b1;
                end
                if (s_dr_ahs) dr_addr_valid = 1'b0;
                if (!dr_addr_valid && dr_q.size() > 0) begin
                    dr_addr = dr_q.pop_front(); dr_addr_valid = 1'b1;
                end
                ir_data_ready = ir_dready;
                dr_data_ready = dr_dready;
                r_addr_ready  = mem_aready;
                if (s_mem_dhs || stray_on) begin
                    r_data_valid = 1'b0; r_data = '0; stray_on = 1'b0;
                end
                if (s_mem_ahs) begin
                    pend = 1'b1; cnt = mem_lat; paddr = s_mem_addr;
                end
                if (pend) begin
                    cnt--;
                    if (cnt <= 0) begin
                        r_data_valid = 1'b1; r_data = paddr ^ KEY; pend = 1'b0;
                    end
                end
                if (stray_req) begin
                    r_data_valid = 1'b1; r_data = 32'h55; stray_req = 1'b0; stray_on = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake the DUT presents
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (ir_data_valid) ir_dv_cycles++;
                if (dr_data_valid) dr_dv_cycles++;
                if (ir_data_valid && dr_data_valid) chk_b("both_data_valid", 1'b1, 1'b0);
                if (ir_addr_ready && dr_addr_ready) chk_b("both_addr_ready", 1'b1, 1'b0);
                if (r_addr_valid && r_addr_ready) begin
                    if (exp_addr.size() == 0) chk_w("r_addr_unexpected", r_addr, 32'hFFFF_FFFF);
                    else chk_w("r_addr", r_addr, exp_addr.pop_front());
                    chk_b("idle_gap", cyc > last_dhs_cyc, 1'b1);
                    if (dr_addr_valid && dr_addr_ready) dr_ahs_cyc = cyc;
                end
                if (ir_data_valid && ir_data_ready) begin
                    if (exp_ir.size() == 0) chk_w("ir_data_unexpected", ir_data, 32'hFFFF_FFFF);
                    else chk_w("ir_data", ir_data, exp_ir.pop_front());
                    ir_dhs_cyc = cyc; last_dhs_cyc = cyc;
                end
                if (dr_data_valid && dr_data_ready) begin
                    if (exp_dr.size() == 0) chk_w("dr_data_unexpected", dr_data, 32'hFFFF_FFFF);
                    else chk_w("dr_data", dr_data, exp_dr.pop_front());
                    last_dhs_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_addr.size() != 0 || exp_ir.size() != 0 || exp_dr.size() != 0 ||
                ir_q.size() != 0 || dr_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk_b({name, "_timeout"}, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ir_dv(input string name);
        int k;
        k = 0;
        while (!ir_data_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!ir_data_valid) chk_b({name, "_timeout"}, 1'b1, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_b("rst_r_addr_valid", r_addr_valid, 1'b0);
        chk_b("rst_r_data_ready", r_data_ready, 1'b0);
        chk_w("rst_state", 32'(dut.state), 32'(RD_ARB_IDLE));
        chk_b("rst_last_grant", dut.last_grant, RD_ARB_D);
        chk_b("rst_owner", dut.owner, RD_ARB_I);
        chk_b("rst_protocol_error", protocol_error, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Tie on the first cycle after reset: ir first, then dr
        ir_q.push_back(32'h10);  dr_q.push_back(32'h20);
        exp_addr.push_back(32'h10); exp_addr.push_back(32'h20);
        exp_ir.push_back(32'hDEADBFFF); exp_dr.push_back(32'hDEADBFCF);
        wait_idle("tie");

        // Continuous requests from both: I, D, I, D
        mem_lat = 2;
        ir_q.push_back(32'h30);  ir_q.push_back(32'h50);
        dr_q.push_back(32'h40);  dr_q.push_back(32'h200);
        exp_addr.push_back(32'h30); exp_addr.push_back(32'h40);
        exp_addr.push_back(32'h50); exp_addr.push_back(32'h200);
        exp_ir.push_back(32'hDEADBFDF); exp_ir.push_back(32'hDEADBFBF);
        exp_dr.push_back(32'hDEADBFAF); exp_dr.push_back(32'hDEADBDEF);
        wait_idle("alternate");
        mem_lat = 1;

        // ir alone
        ir_dv_cycles = 0; dr_dv_cycles = 0;
        ir_q.push_back(32'h100);
        exp_addr.push_back(32'h100); exp_ir.push_back(32'hDEADBEEF);
        wait_idle("ir_only");
        chk_w("ir_only_dv_cycles", ir_dv_cycles, 32'd1);
        chk_w("ir_only_dr_dv_cycles", dr_dv_cycles, 32'd0);

        // Address stall: grant stays locked to ir while dr arrives
        mem_aready = 1'b0;
        ir_q.push_back(32'h300);
        exp_addr.push_back(32'h300); exp_ir.push_back(32'hDEADBCEF);
        @(negedge clk);
        dr_q.push_back(32'h400);
        exp_addr.push_back(32'h400); exp_dr.push_back(32'hDEADBBEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_w("stall_state", 32'(dut.state), 32'(RD_ARB_ADDR));
            chk_b("stall_r_addr_valid", r_addr_valid, 1'b1);
            chk_w("stall_r_addr", r_addr, 32'h300);
            chk_b("stall_dr_addr_ready", dr_addr_ready, 1'b0);
        end
        mem_aready = 1'b1;
        wait_idle("stall");

        // Data backpressure with a dr request arriving during DATA
        ir_dready = 1'b0;
        ir_q.push_back(32'h10);
        exp_addr.push_back(32'h10); exp_ir.push_back(32'hDEADBFFF);
        wait_ir_dv("bp");
        chk_b("bp_r_data_ready0", r_data_ready, 1'b0);
        chk_w("bp_ir_data0", ir_data, 32'hDEADBFFF);
        dr_q.push_back(32'h20);
        exp_addr.push_back(32'h20); exp_dr.push_back(32'hDEADBFCF);
        @(negedge clk);
        chk_b("bp_ir_data_valid1", ir_data_valid, 1'b1);
        chk_b("bp_r_data_ready1", r_data_ready, 1'b0);
        chk_b("bp_dr_addr_ready1", dr_addr_ready, 1'b0);
        chk_b("bp_dr_data_valid1", dr_data_valid, 1'b0);
        ir_dready = 1'b1;
        wait_idle("bp");
        chk_w("bp_dr_accept_cycle", dr_ahs_cyc, ir_dhs_cyc + 1);

        // Reset in the middle of DATA, then a stray memory response
        ir_dready = 1'b0;
        ir_q.push_back(32'h100);
        exp_addr.push_back(32'h100);
        wait_ir_dv("mid_rst");
        #2 rst = 1'b0;
        #1;
        chk_b("mid_rst_ir_data_valid", ir_data_valid, 1'b0);
        chk_w("mid_rst_ir_data", ir_data, 32'h0);
        chk_b("mid_rst_r_data_ready", r_data_ready, 1'b0);
        chk_b("mid_rst_r_addr_valid", r_addr_valid, 1'b0);
        chk_w("mid_rst_state", 32'(dut.state), 32'(RD_ARB_IDLE));
        chk_b("mid_rst_last_grant", dut.last_grant, RD_ARB_D);
        repeat (2) @(negedge clk);
        ir_dready = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        stray_req = 1'b1;
        @(negedge clk);
        chk_b("stray_ir_data_valid", ir_data_valid, 1'b0);
        chk_b("stray_dr_data_valid", dr_data_valid, 1'b0);
        chk_w("stray_ir_data", ir_data, 32'h0);
        chk_b("stray_r_data_ready", r_data_ready, 1'b0);
        @(negedge clk);
        chk_b("stray_protocol_error", protocol_error, 1'b1);
        repeat (3) @(negedge clk);
        chk_b("sticky_protocol_error", protocol_error, 1'b1);
        #2 rst = 1'b0;
        @(negedge clk);
        chk_b("rst_clears_protocol_error", protocol_error, 1'b0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
